// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// Each cycle at most one eligible request is granted; its operands go to the
// ALU, and the ALU result is captured into that requester's response slot on
// the next rising edge. A full slot blocks its requester until consumed,
// but a slot being consumed in the same cycle may be refilled immediately.
//
// Handshake semantics (both channels): a beat transfers on a rising edge
// where valid & ready are both high; valid may drop without a transfer and
// no state is kept for requests that were never accepted.
module alu_arbiter #(
   parameter bit RR_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req1_a,
   input  logic [31:0] req0_b,
   input  logic [31:0] req1_b,
   input  logic [3:0]  req0_funct,
   input  logic [3:0]  req1_funct,
   output logic [1:0]  rsp_valid,
   input  logic [1:0]  rsp_ready,
   output logic [31:0] rsp0_o,
   output logic [31:0] rsp1_o,
   output logic        rsp0_zero,
   output logic        rsp1_zero,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_funct,
   input  logic [31:0] alu_o,
   input  logic        alu_zero,
   output logic        busy
);

   logic [1:0]  w_elig;
   logic [1:0]  w_grant;
   logic [1:0]  r_rsp_valid;
   logic [31:0] r_rsp0_o;
   logic [31:0] r_rsp1_o;
   logic        r_rsp0_zero;
   logic        r_rsp1_zero;
   logic        r_last_grant;   // index of the requester that last transferred

   // A requester may be granted when its slot is empty or being drained now.
   assign w_elig = req_valid & (~r_rsp_valid | rsp_ready);

   // One-hot grant; forced to zero while reset is asserted.
   always_comb begin
      w_grant = 2'b00;
      if (!rst) begin
         if (RR_EN) begin
            if (&w_elig) begin
               w_grant = r_last_grant ? 2'b01 : 2'b10;
            end else begin
               w_grant = w_elig;
            end
         end else begin
            if (w_elig[0]) begin
               w_grant = 2'b01;
            end else if (w_elig[1]) begin
               w_grant = 2'b10;
            end
         end
      end
   end

   // Steer the granted operands to the ALU; drive zeros when idle.
   always_comb begin
      alu_a     = 32'd0;
      alu_b     = 32'd0;
      alu_funct = 4'd0;
      if (w_grant[0]) begin
         alu_a     = req0_a;
         alu_b     = req0_b;
         alu_funct = req0_funct;
      end else if (w_grant[1]) begin
         alu_a     = req1_a;
         alu_b     = req1_b;
         alu_funct = req1_funct;
      end
   end

   // Capture ALU results into response slots and track the last winner.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rsp_valid  <= 2'b00;
         r_rsp0_o     <= 32'd0;
         r_rsp1_o     <= 32'd0;
         r_rsp0_zero  <= 1'b0;
         r_rsp1_zero  <= 1'b0;
         r_last_grant <= 1'b1;
      end else begin
         if (w_grant[0]) begin
            r_rsp0_o       <= alu_o;
            r_rsp0_zero    <= alu_zero;
            r_rsp_valid[0] <= 1'b1;
         end else if (rsp_ready[0]) begin
            r_rsp_valid[0] <= 1'b0;
         end
         if (w_grant[1]) begin
            r_rsp1_o       <= alu_o;
            r_rsp1_zero    <= alu_zero;
            r_rsp_valid[1] <= 1'b1;
         end else if (rsp_ready[1]) begin
            r_rsp_valid[1] <= 1'b0;
         end
         if (|w_grant) begin
            r_last_grant <= w_grant[1];
         end
      end
   end

   assign req_ready = w_grant;
   assign rsp_valid = r_rsp_valid;
   assign rsp0_o    = r_rsp0_o;
   assign rsp1_o    = r_rsp1_o;
   assign rsp0_zero = r_rsp0_zero;
   assign rsp1_zero = r_rsp1_zero;
   assign busy      = |r_rsp_valid;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin instance and a fixed-priority
// instance share one stimulus set; each gets its own reference ALU model.
module tb_alu_arbiter;

   logic        clk;
   logic        rst;
   logic [1:0]  req_valid;
   logic [31:0] req0_a, req1_a, req0_b, req1_b;
   logic [3:0]  req0_funct, req1_funct;
   logic [1:0]  rsp_ready;

   // round-robin instance outputs
   logic [1:0]  rr_req_ready, rr_rsp_valid;
   logic [31:0] rr_rsp0_o, rr_rsp1_o, rr_alu_a, rr_alu_b, rr_alu_o;
   logic        rr_rsp0_zero, rr_rsp1_zero, rr_alu_zero, rr_busy;
   logic [3:0]  rr_alu_funct;

   // fixed-priority instance outputs
   logic [1:0]  fp_req_ready, fp_rsp_valid;
   logic [31:0] fp_rsp0_o, fp_rsp1_o, fp_alu_a, fp_alu_b, fp_alu_o;
   logic        fp_rsp0_zero, fp_rsp1_zero, fp_alu_zero, fp_busy;
   logic [3:0]  fp_alu_funct;

   int n_total;
   int n_pass;

   // Reference ALU: bit3 selects sub / arithmetic shift.
   function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] f);
      logic [31:0] r;
      case (f[2:0])
         3'd0: r = f[3] ? a - b : a + b;
         3'd1: r = a << b[4:0];
         3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd3: r = (a < b) ? 32'd1 : 32'd0;
         3'd4: r = a ^ b;
         3'd5: r = f[3] ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'd6: r = a | b;
         default: r = a & b;
      endcase
      return {(r == 32'd0), r};
   endfunction

   assign {rr_alu_zero, rr_alu_o} = alu_model(rr_alu_a, rr_alu_b, rr_alu_funct);
   assign {fp_alu_zero, fp_alu_o} = alu_model(fp_alu_a, fp_alu_b, fp_alu_funct);

   alu_arbiter #(.RR_EN(1'b1)) u_rr (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(rr_req_ready),
      .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
      .req0_funct(req0_funct), .req1_funct(req1_funct),
      .rsp_valid(rr_rsp_valid), .rsp_ready(rsp_ready),
      .rsp0_o(rr_rsp0_o), .rsp1_o(rr_rsp1_o),
      .rsp0_zero(rr_rsp0_zero), .rsp1_zero(rr_rsp1_zero),
      .alu_a(rr_alu_a), .alu_b(rr_alu_b), .alu_funct(rr_alu_funct),
      .alu_o(rr_alu_o), .alu_zero(rr_alu_zero), .busy(rr_busy)
   );

   alu_arbiter #(.RR_EN(1'b0)) u_fp (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(fp_req_ready),
      .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
      .req0_funct(req0_funct), .req1_funct(req1_funct),
      .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready),
      .rsp0_o(fp_rsp0_o), .rsp1_o(fp_rsp1_o),
      .rsp0_zero(fp_rsp0_zero), .rsp1_zero(fp_rsp1_zero),
      .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_funct(fp_alu_funct),
      .alu_o(fp_alu_o), .alu_zero(fp_alu_zero), .busy(fp_busy)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // advance to 1 time unit after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req_valid  = 2'b00;
      rsp_ready  = 2'b00;
      req0_a     = 32'd0;
      req0_b     = 32'd0;
      req0_funct = 4'd0;
      req1_a     = 32'd0;
      req1_b     = 32'd0;
      req1_funct = 4'd0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      clear_inputs();
      rst = 1'b1;
      #2;
      // reset state
      check("rst_rsp_valid", {30'd0, rr_rsp_valid}, 32'd0);
      check("rst_busy", {31'd0, rr_busy}, 32'd0);
      check("rst_rsp0_o", rr_rsp0_o, 32'd0);
      check("rst_req_ready", {30'd0, rr_req_ready}, 32'd0);
      do_reset();

      // single op: 5 - 3
      req_valid = 2'b01; req0_a = 32'd5; req0_b = 32'd3; req0_funct = 4'h8;
      #1;
      check("single_req_ready", {30'd0, rr_req_ready}, 32'h1);
      check("single_alu_a", rr_alu_a, 32'd5);
      step();
      req_valid = 2'b00;
      check("single_rsp_valid", {30'd0, rr_rsp_valid}, 32'h1);
      check("single_rsp0_o", rr_rsp0_o, 32'd2);
      check("single_rsp0_zero", {31'd0, rr_rsp0_zero}, 32'd0);
      check("single_busy", {31'd0, rr_busy}, 32'd1);
      #1;
      check("idle_alu_a", rr_alu_a, 32'd0);
      check("idle_alu_funct", {28'd0, rr_alu_funct}, 32'd0);

      // round-robin contention
      do_reset();
      req_valid = 2'b11; rsp_ready = 2'b11;
      req0_a = 32'd1; req0_b = 32'd1; req0_funct = 4'h0;
      req1_a = 32'd7; req1_b = 32'd7; req1_funct = 4'h4;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("rr_grant_%0d", i), {30'd0, rr_req_ready}, (i % 2 == 0) ? 32'h1 : 32'h2);
         step();
      end
      check("rr_rsp0_o", rr_rsp0_o, 32'd2);
      check("rr_rsp0_zero", {31'd0, rr_rsp0_zero}, 32'd0);
      check("rr_rsp1_o", rr_rsp1_o, 32'd0);
      check("rr_rsp1_zero", {31'd0, rr_rsp1_zero}, 32'd1);
      check("rr_rsp_valid", {30'd0, rr_rsp_valid}, 32'h2);

      // fixed priority contention
      do_reset();
      req_valid = 2'b11; rsp_ready = 2'b11;
      req0_a = 32'd1; req0_b = 32'd1; req0_funct = 4'h0;
      req1_a = 32'd7; req1_b = 32'd7; req1_funct = 4'h4;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("fp_grant_%0d", i), {30'd0, fp_req_ready}, 32'h1);
         step();
      end
      check("fp_rsp_valid", {30'd0, fp_rsp_valid}, 32'h1);

      // backpressure on slot 0
      do_reset();
      req_valid = 2'b01; req0_a = 32'h8; req0_b = 32'h8; req0_funct = 4'h0;
      step();
      check("bp_fill_rsp0_o", rr_rsp0_o, 32'h10);
      req_valid = 2'b11; rsp_ready = 2'b10;
      req0_a = 32'h20; req0_b = 32'h1;
      req1_a = 32'd1; req1_b = 32'd2; req1_funct = 4'h0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("bp_grant_%0d", i), {30'd0, rr_req_ready}, 32'h2);
         step();
         check($sformatf("bp_rsp0_o_%0d", i), rr_rsp0_o, 32'h10);
         check($sformatf("bp_rsp0_valid_%0d", i), {31'd0, rr_rsp_valid[0]}, 32'd1);
         check($sformatf("bp_rsp1_o_%0d", i), rr_rsp1_o, 32'd3);
      end
      rsp_ready = 2'b11;
      #1;
      check("bp_release_grant", {30'd0, rr_req_ready}, 32'h1);
      step();
      check("bp_release_rsp0_o", rr_rsp0_o, 32'h21);

      // shift / compare pass-through
      do_reset();
      rsp_ready = 2'b11; req_valid = 2'b10;
      req1_a = 32'h8000_0000; req1_b = 32'd4; req1_funct = 4'hD;
      #1;
      check("sra_grant", {30'd0, rr_req_ready}, 32'h2);
      step();
      check("sra_rsp1_o", rr_rsp1_o, 32'hF800_0000);
      req1_a = 32'hFFFF_FFFF; req1_b = 32'd1; req1_funct = 4'h3;
      step();
      check("sltu_rsp1_o", rr_rsp1_o, 32'd0);
      check("sltu_rsp1_zero", {31'd0, rr_rsp1_zero}, 32'd1);

      // asynchronous reset mid-cycle with both slots full
      do_reset();
      req_valid = 2'b11;
      req0_a = 32'd1; req0_b = 32'd1; req0_funct = 4'h0;
      req1_a = 32'd3; req1_b = 32'd4; req1_funct = 4'h0;
      step();
      step();
      check("ar_pre_rsp_valid", {30'd0, rr_rsp_valid}, 32'h3);
      check("ar_pre_rsp1_o", rr_rsp1_o, 32'd7);
      #2 rst = 1'b1;
      #1;
      check("ar_rsp_valid", {30'd0, rr_rsp_valid}, 32'd0);
      check("ar_rsp0_o", rr_rsp0_o, 32'd0);
      check("ar_rsp1_o", rr_rsp1_o, 32'd0);
      check("ar_busy", {31'd0, rr_busy}, 32'd0);
      check("ar_req_ready", {30'd0, rr_req_ready}, 32'd0);
      #1 rst = 1'b0;
      rsp_ready = 2'b11;
      #1;
      check("ar_first_grant", {30'd0, rr_req_ready}, 32'h1);
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU instance between two requesters, e.g. the integer pipeline and an address-generation/iterative unit.
- Each requester has a valid/ready request channel (a, b, funct) and a valid/ready response channel (result, zero).
- The block picks one request per cycle, drives the ALU operand inputs, and registers the ALU result into a per-requester response slot.
- The slot holds its result until the requester consumes it.

Parameters:
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, requester 0 always wins.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester request accepted this cycle.
- req0_a, req1_a  in  32  operand a.
- req0_b, req1_b  in  32  operand b.
- req0_funct, req1_funct  in  4  ALU function code: bit3 = sub/arith, bits2:0 = op.
- rsp_valid  out  2  per-requester response slot full.
- rsp_ready  in  2  per-requester response consumed.
- rsp0_o, rsp1_o  out  32  registered result.
- rsp0_zero, rsp1_zero  out  1  registered zero flag.
- alu_a  out  32  to ALU operand a.
- alu_b  out  32  to ALU operand b.
- alu_funct  out  4  to ALU function code.
- alu_o  in  32  from ALU result.
- alu_zero  in  1  from ALU zero flag.
- busy  out  1  high when any response slot is full.

Behaviour:
- Reset (async, rst high): rsp_valid = 00, rsp*_o = 0, rsp*_zero = 0, last_grant = 1 (so requester 0 wins first), busy = 0. req_ready is combinational and, with rst high, evaluates to 00.
- Eligibility: requester i is eligible when req_valid[i] = 1 AND (rsp_valid[i] = 0 OR rsp_ready[i] = 1). Same-cycle drain-and-refill of a slot is allowed.
- Grant, one-hot, combinational, at most one bit per cycle:
  - RR_EN = 1: if both are eligible, grant the requester that is not last_grant. If only one is eligible, grant it.
  - RR_EN = 0: requester 0 wins whenever it is eligible.
- req_ready = grant. A transfer occurs when req_valid[i] & req_ready[i].
- ALU drive while a grant is active: alu_a / alu_b / alu_funct = the granted requester's operands.
- ALU drive with no grant: alu_a = 0, alu_b = 0, alu_funct = 0, for power and determinism.
- Clock edge with a transfer to requester i:
  - rsp_i_o <= alu_o, rsp_i_zero <= alu_zero, rsp_valid[i] <= 1.
  - last_grant <= i, updated only on a transfer, in both RR modes.
- Clock edge with rsp_valid[i] & rsp_ready[i] and no new transfer to i: rsp_valid[i] <= 0. Data registers hold their value.
- Latency: result visible one cycle after acceptance. Combined throughput is one operation per cycle; per requester it is one per cycle while its consumer keeps rsp_ready high.
- Backpressure: with rsp_valid[i] = 1 and rsp_ready[i] = 0, requester i is never granted. The other requester may use the ALU.
- Response outputs are stable while rsp_valid = 1 and rsp_ready = 0.
- busy = |rsp_valid.
- Reset mid-operation: in-flight results are discarded and slots clear immediately.
- req_valid may drop without a handshake; the block keeps no state for unaccepted requests.

Test Plan:
- Single op: req0 a = 5, b = 3, funct = 0x8 (sub). Required: req_ready = 01 in the same cycle; next cycle rsp_valid = 01, rsp0_o = 2, rsp0_zero = 0.
- Contention, RR_EN = 1: both request every cycle, rsp_ready = 11, req0 = add(1,1), req1 = xor(7,7). Grants alternate 0,1,0,1 starting with 0. rsp1_o = 0 with rsp1_zero = 1; rsp0_o = 2.
- Fixed priority, RR_EN = 0: both request continuously for 4 cycles with rsp_ready = 11. Required: req_ready = 01 every cycle and requester 1 is never granted.
- Backpressure: slot 0 full with rsp0_o = 0x10 and rsp_ready[0] = 0 for 3 cycles while req0 and req1 both request. Required: req_ready[0] = 0 throughout, rsp0_o stays 0x10, requester 1 is granted. When rsp_ready[0] = 1, req0 is granted in that same cycle.
- Shift/compare pass-through: req1 a = 0x80000000, b = 4, funct = 0xD (sra). Required: rsp1_o = 0xF8000000. Then a = 0xFFFFFFFF, b = 1, funct = 0x3 (sltu). Required: rsp1_o = 0.
- Async reset: assert rst mid-cycle with rsp_valid = 11. Required: rsp_valid = 00, outputs 0 and busy = 0 before the next clock edge. After release, the first contended grant goes to requester 0.
